lsu_mem_ctrl: RTL and testbench

Load/store controller between the RV32I execute stage and the single-port 1024×32 data RAM. Accepts one byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and drives the RAM's en/we/rd/addr/di port. Extracts and sign/zero-extends load data. Because the RAM has no byte enables, SB/SH are done as read-modify-write.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/lsu_align.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 98 +++++++++
 tb/tb_lsu_mem_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I load/store encodings and LSU state type.
package riscv_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [2:0] {LSU_IDLE, LSU_RD, LSU_WAIT, LSU_WR, LSU_ERR} lsu_state_e;
   function automatic logic lsu_bad(input logic [2:0] f3, input logic [1:0] lane);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
             (f3[1:0] == 2'b01 && lane[0]) || (f3 == F3_W && lane != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extraction with sign/zero extension, and store lane merge.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic [31:0] o_merged
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   assign w_byte = i_word[{i_lane, 3'b000} +: 8];
   assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];
   always_comb begin
      o_rdata  = i_word;
      o_merged = i_wdata;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_rdata = {24'h0, w_byte};
         F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_rdata = {16'h0, w_half};
         default: o_rdata = i_word;
      endcase
      if (i_funct3[1:0] == 2'b00) begin
         o_merged = i_word;
         o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end else if (i_funct3[1:0] == 2'b01) begin
         o_merged = i_word;
         o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
   end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-at-a-time RV32I load/store controller for a single-port word RAM.
// Sub-word stores are read-modify-write since the RAM has no byte enables.
module lsu_mem_ctrl
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_funct3,
   input  logic [31:0]       i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic              o_rsp_err,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic              o_ram_rd,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [31:0]       o_ram_di,
   input  logic [31:0]       i_ram_dout
);
   lsu_state_e        r_state, w_next;
   logic              r_we, r_ram_en, r_ram_we, r_ram_rd, r_rsp_valid, r_rsp_err;
   logic [2:0]        r_f3;
   logic [1:0]        r_lane;
   logic [31:0]       r_wdata, r_buf, r_rsp_rdata, w_rdata, w_merged;
   logic [ADDR_W-1:0] r_addr;
   logic              w_acc, w_load_done;
   assign w_acc       = i_req_valid && r_state == LSU_IDLE;
   assign w_load_done = r_state == LSU_WAIT && !r_we;
   assign o_req_ready = r_state == LSU_IDLE;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_ram_en    = r_ram_en;
   assign o_ram_we    = r_ram_we;
   assign o_ram_rd    = r_ram_rd;
   assign o_ram_addr  = r_addr;
   assign o_ram_di    = r_buf;
   lsu_align u_align (
      .i_funct3 (r_f3),
      .i_lane   (r_lane),
      .i_word   (i_ram_dout),
      .i_wdata  (r_wdata),
      .o_rdata  (w_rdata),
      .o_merged (w_merged)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         LSU_IDLE: if (w_acc) w_next = lsu_bad(i_req_funct3, i_req_addr[1:0]) ? LSU_ERR :
                                       (i_req_we && i_req_funct3 == F3_W) ? LSU_WR : LSU_RD;
         LSU_RD:   w_next = LSU_WAIT;
         LSU_WAIT: w_next = r_we ? LSU_WR : LSU_IDLE;
         default:  w_next = LSU_IDLE;
      endcase
   end
   // RAM strobes are registered from the next state so they line up with RD/WR.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= LSU_IDLE;
         r_we        <= 1'b0;
         r_f3        <= '0;
         r_lane      <= '0;
         r_wdata     <= '0;
         r_addr      <= '0;
         r_buf       <= '0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_rd    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_next;
         r_ram_en    <= w_next == LSU_RD || w_next == LSU_WR;
         r_ram_we    <= w_next == LSU_WR;
         r_ram_rd    <= w_next == LSU_RD;
         r_rsp_valid <= w_load_done || r_state == LSU_WR || r_state == LSU_ERR;
         r_rsp_err   <= r_state == LSU_ERR;
         r_rsp_rdata <= w_load_done ? w_rdata : '0;
         if (w_acc) begin
            r_we    <= i_req_we;
            r_f3    <= i_req_funct3;
            r_lane  <= i_req_addr[1:0];
            r_wdata <= i_req_wdata;
            r_addr  <= i_req_addr[ADDR_W+1:2];
            r_buf   <= i_req_wdata;
         end else if (r_state == LSU_WAIT) begin
            r_buf <= w_merged;
         end
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: random + directed bench; a cycle-indexed expectation model is checked every cycle.
module tb_lsu_mem_ctrl;
   localparam int N = 8192;
   logic        clk = 0, rst_n = 0;
   logic        req_valid = 0, req_we = 0;
   logic [2:0]  req_f3 = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, rsp_valid, rsp_err, ram_en, ram_we, ram_rd;
   logic [31:0] rsp_rdata, ram_di, ram_dout = 0;
   logic [9:0]  ram_addr;

   logic [31:0] ram [1024];
   logic [31:0] ref_mem [1024];
   bit          e_rsp [N];
   bit          e_err [N];
   logic [31:0] e_dat [N];
   bit          e_rd [N];
   bit          e_wr [N];
   int          e_addr [N];
   logic [31:0] e_di [N];
   int          cyc = 0, busy_until = 0, n_chk = 0, n_err = 0;
   bit          chk_on = 0;

   lsu_mem_ctrl #(.ADDR_W(10)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_rd(ram_rd), .o_ram_addr(ram_addr),
      .o_ram_di(ram_di), .i_ram_dout(ram_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_di;
      if (ram_rd) ram_dout <= ram[ram_addr];
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endfunction

   function automatic logic [31:0] ld_model(logic [31:0] word, logic [2:0] f3, int ln);
      int sh;
      logic [31:0] m, v;
      if (f3[1:0] == 2'd2) return word;
      sh = (f3[1:0] == 2'd0) ? 8 * ln : 16 * (ln / 2);
      m  = (f3[1:0] == 2'd0) ? 32'hFF : 32'hFFFF;
      v  = (word >> sh) & m;
      if (!f3[2] && (v & ((m + 1) >> 1)) != 0) v = v | ~m;
      return v;
   endfunction

   function automatic logic [31:0] st_model(logic [31:0] old, logic [2:0] f3, int ln, logic [31:0] wd);
      int sh;
      logic [31:0] m;
      if (f3[1:0] == 2'd2) return wd;
      sh = (f3[1:0] == 2'd0) ? 8 * ln : 16 * (ln / 2);
      m  = (f3[1:0] == 2'd0) ? 32'hFF : 32'hFFFF;
      return (old & ~(m << sh)) | ((wd & m) << sh);
   endfunction

   function automatic void put_rsp(int c, bit err, logic [31:0] d);
      if (c < N) begin e_rsp[c] = 1; e_err[c] = err; e_dat[c] = d; end
      busy_until = c;
   endfunction

   function automatic void put_ram(int c, bit wr, int w, logic [31:0] di);
      if (c < N) begin
         if (wr) begin e_wr[c] = 1; e_di[c] = di; end else e_rd[c] = 1;
         e_addr[c] = w;
      end
   endfunction

   function automatic void model(int acc, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
      int w, ln;
      bit bad;
      logic [31:0] nw;
      w   = (a / 4) % 1024;
      ln  = a % 4;
      bad = (f3 == 3 || f3 == 6 || f3 == 7) || (f3[1:0] == 2'd1 && ln % 2 == 1) ||
            (f3[1:0] == 2'd2 && ln != 0);
      if (bad) put_rsp(acc + 2, 1, 0);
      else if (!we) begin
         put_ram(acc + 1, 0, w, 0);
         put_rsp(acc + 3, 0, ld_model(ref_mem[w], f3, ln));
      end else if (f3[1:0] == 2'd2) begin
         put_ram(acc + 1, 1, w, wd);
         ref_mem[w] = wd;
         put_rsp(acc + 2, 0, 0);
      end else begin
         nw = st_model(ref_mem[w], f3, ln, wd);
         put_ram(acc + 1, 0, w, 0);
         put_ram(acc + 3, 1, w, nw);
         ref_mem[w] = nw;
         put_rsp(acc + 4, 0, 0);
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         if (chk_on && rst_n && cyc < N) begin
            chk("ready", req_ready, cyc >= busy_until);
            chk("rsp_valid", rsp_valid, e_rsp[cyc]);
            if (e_rsp[cyc]) begin
               chk("rsp_err", rsp_err, e_err[cyc]);
               chk("rsp_rdata", rsp_rdata, e_dat[cyc]);
            end
            chk("ram_en", ram_en, e_rd[cyc] | e_wr[cyc]);
            chk("ram_we", ram_we, e_wr[cyc]);
            chk("ram_rd", ram_rd, e_rd[cyc]);
            if (e_rd[cyc] | e_wr[cyc]) chk("ram_addr", ram_addr, e_addr[cyc]);
            if (e_wr[cyc]) chk("ram_di", ram_di, e_di[cyc]);
         end
      end
   end

   task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit mdl, output int acc);
      int n = 0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("accept_timeout", 0, 1);
      acc = cyc;
      if (mdl) model(acc, we, f3, a, wd);
   endtask

   task automatic rel();
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic wait_rsp(input string nm, input int acc, input int lat, input bit err,
                           input logic [31:0] d);
      int n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk({nm, "_latency"}, cyc - acc, lat);
      chk({nm, "_err"}, rsp_err, err);
      chk({nm, "_rdata"}, rsp_rdata, d);
   endtask

   task automatic chk_reset();
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_rd", ram_rd, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_di", ram_di, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2;
      logic [31:0] v, old;
      bit we;
      logic [2:0] f3;
      for (int i = 0; i < 1024; i++) begin
         v = $urandom;
         ram[i] = v;
         ref_mem[i] = v;
      end
      repeat (2) @(negedge clk);
      chk_reset();
      rst_n = 1;
      chk_on = 1;

      chk("model_lb", ld_model(32'hDEADBEEF, 3'b000, 3), 32'hFFFFFFDE);
      chk("model_lhu", ld_model(32'hDEADBEEF, 3'b101, 2), 32'h0000DEAD);
      chk("model_sb", st_model(32'hDEADBEEF, 3'b000, 1, 32'h12345655), 32'hDEAD55EF);

      send(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, acc); rel();
      chk("sw_we_c1", ram_we, 1);
      chk("sw_addr_c1", ram_addr, 4);
      chk("sw_di_c1", ram_di, 32'hDEADBEEF);
      wait_rsp("sw", acc, 2, 0, 0);
      send(0, 3'b000, 32'h13, 0, 1, acc); rel(); wait_rsp("lb", acc, 3, 0, 32'hFFFFFFDE);
      send(0, 3'b100, 32'h13, 0, 1, acc); rel(); wait_rsp("lbu", acc, 3, 0, 32'h000000DE);
      send(0, 3'b001, 32'h10, 0, 1, acc); rel(); wait_rsp("lh", acc, 3, 0, 32'hFFFFBEEF);
      send(0, 3'b101, 32'h12, 0, 1, acc); rel(); wait_rsp("lhu", acc, 3, 0, 32'h0000DEAD);
      send(1, 3'b000, 32'h11, 32'h12345655, 1, acc); rel(); wait_rsp("sb", acc, 4, 0, 0);
      send(0, 3'b010, 32'h10, 0, 1, acc); rel(); wait_rsp("lw_after_sb", acc, 3, 0, 32'hDEAD55EF);
      send(0, 3'b010, 32'h12, 0, 1, acc); rel(); wait_rsp("err_lw", acc, 2, 1, 0);
      send(1, 3'b001, 32'h11, 32'h1234, 1, acc); rel(); wait_rsp("err_sh", acc, 2, 1, 0);
      send(0, 3'b011, 32'h10, 0, 1, acc); rel(); wait_rsp("err_f3", acc, 2, 1, 0);

      send(1, 3'b010, 32'h40, 32'hCAFEF00D, 1, acc);
      send(0, 3'b010, 32'h40, 0, 1, acc2);
      chk("b2b_accept", acc2 - acc, 2);
      rel(); wait_rsp("b2b_lw", acc2, 3, 0, 32'hCAFEF00D);

      for (int k = 0; k < 300; k++) begin
         we = $urandom_range(0, 1);
         f3 = 3'($urandom_range(0, 7));
         if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
         v = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         send(we, f3, v, $urandom, 1, acc);
         if ($urandom_range(0, 2) != 0) rel();
      end
      rel();
      repeat (6) @(posedge clk);

      old = ref_mem[8];
      send(1, 3'b001, 32'h22, 32'h0000ABCD, 0, acc);
      put_ram(acc + 1, 0, 8, 0);
      busy_until = acc + 3;
      rel();
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_wait", cyc - acc, 2);
      rst_n = 0;
      #1;
      chk_reset();
      @(negedge clk);
      rst_n = 1;
      send(0, 3'b010, 32'h20, 0, 1, acc); rel();
      wait_rsp("rst_keep", acc, 3, 0, old);
      repeat (4) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
